// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : calc_pkg
//  Description : Shared types, defaults and helpers for the keypad digit-entry
//                accumulator (FSM state encoding, magnitude range limit).
//  Revision    : 1.0  initial release
// ============================================================================
package calc_pkg;

   // Default operand width and digit budget
   localparam int ENTRY_WIDTH      = 8;
   localparam int ENTRY_MAX_DIGITS = 3;

   // Entry FSM states
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      X8   = 3'd1,
      X2   = 3'd2,
      ADD  = 3'd3,
      HOLD = 3'd4
   } state_t;

   // Largest magnitude representable for the given sign:
   // 2^(width-1)-1 when positive, 2^(width-1) when negative.
   function automatic logic [31:0] mag_limit(input logic sign, input int unsigned width);
      return (32'd1 << (width - 1)) - {31'd0, ~sign};
   endfunction

endpackage
`default_nettype wire

// File: rtl/entry_mul10_step.sv
`default_nettype none
// ============================================================================
//  Module      : entry_mul10_step
//  Description : Registered shift-add datapath computing acc*10+digit in three
//                steps: tmp=acc<<3, tmp+=acc<<1, then sum=tmp+digit
//                (combinational, consumed by the controller in its ADD step).
//  Revision    : 1.0  initial release
// ============================================================================
module entry_mul10_step
   import calc_pkg::*;
#(
   parameter int WIDTH = ENTRY_WIDTH
) (
   input  logic             clk,
   input  logic             rst,        // asynchronous, active-low
   input  logic             i_load_x8,
   input  logic             i_add_x2,
   input  logic [WIDTH-1:0] i_acc,
   input  logic [3:0]       i_digit,
   output logic [WIDTH+3:0] o_tmp,
   output logic [WIDTH+3:0] o_sum
);

   // Four guard bits: acc*10+9 with acc < 2^WIDTH never wraps
   localparam int c_TW = WIDTH + 4;

   logic [c_TW-1:0] r_tmp;

   // Partial product register: x8 load, then x2 accumulate
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tmp <= '0;
      end else if (i_load_x8) begin
         r_tmp <= c_TW'({i_acc, 3'b000});
      end else if (i_add_x2) begin
         r_tmp <= r_tmp + c_TW'({i_acc, 1'b0});
      end
   end

   assign o_tmp = r_tmp;
   assign o_sum = r_tmp + c_TW'(i_digit);

endmodule
`default_nettype wire

// File: rtl/digit_entry_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : digit_entry_accumulator
//  Description : Converts a serial stream of keypad BCD digits into a signed
//                two's-complement operand using shift-add (acc*10+digit),
//                with sign toggle, clear, overflow detection and a
//                valid/ready operand handoff.
//                Build option ENTRY_SAT_EN: overflow clamps to the range
//                limit instead of rejecting the digit / sign toggle.
//  Revision    : 1.0  initial release
// ============================================================================
module digit_entry_accumulator
   import calc_pkg::*;
#(
   parameter int WIDTH      = ENTRY_WIDTH,
   parameter int MAX_DIGITS = ENTRY_MAX_DIGITS
) (
   input  logic                             clk,
   input  logic                             rst,          // asynchronous, active-low
   input  logic                             digit_valid,
   output logic                             digit_ready,
   input  logic [3:0]                       digit,
   input  logic                             neg_key,
   input  logic                             clr,
   input  logic                             commit,
   output logic                             value_valid,
   input  logic                             value_ready,
   output logic [WIDTH-1:0]                 value,
   output logic                             busy,
   output logic                             ovf,
   output logic [$clog2(MAX_DIGITS+1)-1:0]  digit_count
);

   localparam int c_TW = WIDTH + 4;
   localparam int c_CW = $clog2(MAX_DIGITS + 1);

`ifdef ENTRY_SAT_EN
   localparam bit c_SAT_EN = 1'b1;
`else
   localparam bit c_SAT_EN = 1'b0;
`endif

   state_t            r_state, w_state_next;
   logic [WIDTH-1:0]  r_acc, w_acc_next;
   logic              r_sign, w_sign_next;
   logic [c_CW-1:0]   r_count, w_count_next;
   logic              r_ovf, w_ovf_next;
   logic [3:0]        r_digit, w_digit_next;
   logic [WIDTH-1:0]  r_value, w_value_next;

   logic [c_TW-1:0]   w_tmp;
   logic [c_TW-1:0]   w_sum;
   logic [c_TW-1:0]   w_limit;       // limit for the current sign
   logic [c_TW-1:0]   w_limit_flip;  // limit if the sign were toggled
   logic              w_accept;

   entry_mul10_step #(
      .WIDTH (WIDTH)
   ) u_mul10 (
      .clk       (clk),
      .rst       (rst),
      .i_load_x8 (r_state == X8),
      .i_add_x2  (r_state == X2),
      .i_acc     (r_acc),
      .i_digit   (r_digit),
      .o_tmp     (w_tmp),
      .o_sum     (w_sum)
   );

   assign w_limit      = c_TW'(mag_limit(r_sign, WIDTH));
   assign w_limit_flip = c_TW'(mag_limit(~r_sign, WIDTH));

   assign value_valid = (r_state == HOLD);
   assign digit_ready = (r_state == IDLE) && (r_count < c_CW'(MAX_DIGITS)) && !value_valid;
   assign w_accept    = digit_valid && digit_ready;
   assign busy        = (r_state == X8) || (r_state == X2) || (r_state == ADD);
   assign ovf         = r_ovf;
   assign digit_count = r_count;
   assign value       = r_value;

   // State and entry registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_acc   <= '0;
         r_sign  <= 1'b0;
         r_count <= '0;
         r_ovf   <= 1'b0;
         r_digit <= '0;
         r_value <= '0;
      end else begin
         r_state <= w_state_next;
         r_acc   <= w_acc_next;
         r_sign  <= w_sign_next;
         r_count <= w_count_next;
         r_ovf   <= w_ovf_next;
         r_digit <= w_digit_next;
         r_value <= w_value_next;
      end
   end

   // Next-state logic: clr overrides everything, then per-state behaviour
   always_comb begin
      w_state_next = r_state;
      w_acc_next   = r_acc;
      w_sign_next  = r_sign;
      w_count_next = r_count;
      w_ovf_next   = r_ovf;
      w_digit_next = r_digit;
      w_value_next = r_value;

      if (clr) begin
         w_state_next = IDLE;
         w_acc_next   = '0;
         w_sign_next  = 1'b0;
         w_count_next = '0;
         w_ovf_next   = 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  // Non-decimal codes complete the handshake but are dropped
                  if (digit <= 4'd9) begin
                     w_digit_next = digit;
                     w_state_next = X8;
                  end
               end else if (commit) begin
                  if (r_count == '0) begin
                     w_value_next = '0;
                  end else if (r_sign) begin
                     w_value_next = WIDTH'(0) - r_acc;
                  end else begin
                     w_value_next = r_acc;
                  end
                  w_state_next = HOLD;
               end else if (neg_key) begin
                  // 128 cannot become +128: treat as overflow
                  if (c_TW'(r_acc) > w_limit_flip) begin
                     w_ovf_next = 1'b1;
                     if (c_SAT_EN) begin
                        w_acc_next  = w_limit_flip[WIDTH-1:0];
                        w_sign_next = ~r_sign;
                     end
                  end else begin
                     w_sign_next = ~r_sign;
                  end
               end
            end
            X8:  w_state_next = X2;
            X2:  w_state_next = ADD;
            ADD: begin
               w_state_next = IDLE;
               if (w_sum > w_limit) begin
                  w_ovf_next = 1'b1;
                  if (c_SAT_EN) begin
                     w_acc_next   = w_limit[WIDTH-1:0];
                     w_count_next = r_count + c_CW'(1);
                  end
               end else begin
                  w_acc_next   = w_sum[WIDTH-1:0];
                  w_count_next = r_count + c_CW'(1);
               end
            end
            HOLD: begin
               if (value_ready) begin
                  w_state_next = IDLE;
                  w_acc_next   = '0;
                  w_sign_next  = 1'b0;
                  w_count_next = '0;
                  w_ovf_next   = 1'b0;
               end
            end
            default: w_state_next = IDLE;
         endcase
      end
   end

   // The partial product is only observed through w_sum
   logic w_unused_tmp;
   assign w_unused_tmp = ^w_tmp;

endmodule
`default_nettype wire

// File: tb/tb_digit_entry_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_digit_entry_accumulator
//  Description : Self-checking bench for digit_entry_accumulator: a table of
//                digit sequences with expected operands, plus hand-written
//                multi-cycle corner cases (latency, clr, async reset, HOLD).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_digit_entry_accumulator;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       digit_valid = 1'b0;
   logic       digit_ready;
   logic [3:0] digit = 4'd0;
   logic       neg_key = 1'b0;
   logic       clr = 1'b0;
   logic       commit = 1'b0;
   logic       value_valid;
   logic       value_ready = 1'b0;
   logic [7:0] value;
   logic       busy;
   logic       ovf;
   logic [1:0] digit_count;

   int n_checks = 0;
   int n_fail   = 0;

   digit_entry_accumulator #(.WIDTH(8), .MAX_DIGITS(3)) dut (
      .clk         (clk),
      .rst         (rst),
      .digit_valid (digit_valid),
      .digit_ready (digit_ready),
      .digit       (digit),
      .neg_key     (neg_key),
      .clr         (clr),
      .commit      (commit),
      .value_valid (value_valid),
      .value_ready (value_ready),
      .value       (value),
      .busy        (busy),
      .ovf         (ovf),
      .digit_count (digit_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         nd;
      logic [3:0] d0, d1, d2;
      bit         neg;
      logic [7:0] exp_value;
      bit         exp_ovf;
      int         exp_count;
   } vec_t;

   vec_t vecs[8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Offer a digit, wait (bounded) for acceptance, then let the 3-cycle sequence run
   task automatic enter_digit(input logic [3:0] d);
      int w = 0;
      digit = d;
      digit_valid = 1'b1;
      while (!digit_ready && w < 20) begin
         tick();
         w++;
      end
      if (!digit_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL digit_ready_timeout: got 0 expected 1");
         digit_valid = 1'b0;
      end else begin
         tick();
         digit_valid = 1'b0;
         tick();
         tick();
         tick();
      end
   endtask

   task automatic pulse_neg();
      neg_key = 1'b1;
      tick();
      neg_key = 1'b0;
   endtask

   task automatic do_commit();
      commit = 1'b1;
      tick();
      commit = 1'b0;
   endtask

   task automatic handoff();
      value_ready = 1'b1;
      tick();
      value_ready = 1'b0;
   endtask

   initial begin
      // digits, sign, expected value/ovf/count
`ifdef ENTRY_SAT_EN
      vecs[2] = '{3, 4'd1, 4'd2, 4'd8, 1'b0, 8'h7F, 1'b1, 3};
      vecs[5] = '{3, 4'd9, 4'd9, 4'd9, 1'b0, 8'h7F, 1'b1, 3};
      vecs[6] = '{3, 4'd1, 4'd2, 4'd9, 1'b1, 8'h80, 1'b1, 3};
`else
      vecs[2] = '{3, 4'd1, 4'd2, 4'd8, 1'b0, 8'h0C, 1'b1, 2};
      vecs[5] = '{3, 4'd9, 4'd9, 4'd9, 1'b0, 8'h63, 1'b1, 2};
      vecs[6] = '{3, 4'd1, 4'd2, 4'd9, 1'b1, 8'hF4, 1'b1, 2};
`endif
      vecs[0] = '{3, 4'd1, 4'd2, 4'd7, 1'b0, 8'h7F, 1'b0, 3};
      vecs[1] = '{3, 4'd1, 4'd2, 4'd8, 1'b1, 8'h80, 1'b0, 3};
      vecs[3] = '{0, 4'd0, 4'd0, 4'd0, 1'b1, 8'h00, 1'b0, 0};
      vecs[4] = '{2, 4'd4, 4'd2, 4'd0, 1'b1, 8'hD6, 1'b0, 2};
      vecs[7] = '{1, 4'd5, 4'd0, 4'd0, 1'b0, 8'h05, 1'b0, 1};

      // Reset state
      tick();
      tick();
      chk("rst_value_valid", {31'd0, value_valid}, 32'd0);
      chk("rst_value", {24'd0, value}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ovf", {31'd0, ovf}, 32'd0);
      chk("rst_count", {30'd0, digit_count}, 32'd0);
      rst = 1'b1;
      tick();

      // Table-driven operand entry
      for (int i = 0; i < 8; i++) begin
         logic [3:0] ds[3];
         ds[0] = vecs[i].d0;
         ds[1] = vecs[i].d1;
         ds[2] = vecs[i].d2;
         if (vecs[i].neg) pulse_neg();
         for (int k = 0; k < vecs[i].nd; k++) enter_digit(ds[k]);
         chk($sformatf("v%0d_count", i), {30'd0, digit_count}, vecs[i].exp_count);
         chk($sformatf("v%0d_pre_valid", i), {31'd0, value_valid}, 32'd0);
         do_commit();
         chk($sformatf("v%0d_valid", i), {31'd0, value_valid}, 32'd1);
         chk($sformatf("v%0d_value", i), {24'd0, value}, {24'd0, vecs[i].exp_value});
         chk($sformatf("v%0d_ovf", i), {31'd0, ovf}, {31'd0, vecs[i].exp_ovf});
         handoff();
         chk($sformatf("v%0d_post_valid", i), {31'd0, value_valid}, 32'd0);
         chk($sformatf("v%0d_post_count", i), {30'd0, digit_count}, 32'd0);
         chk($sformatf("v%0d_post_ovf", i), {31'd0, ovf}, 32'd0);
      end

      // Latency/busy window; commit while busy is ignored
      digit = 4'd6;
      digit_valid = 1'b1;
      tick();
      digit_valid = 1'b0;
      chk("busy_n1", {31'd0, busy}, 32'd1);
      commit = 1'b1;
      tick();
      commit = 1'b0;
      chk("busy_n2", {31'd0, busy}, 32'd1);
      tick();
      chk("busy_n3", {31'd0, busy}, 32'd1);
      chk("count_before_add", {30'd0, digit_count}, 32'd0);
      tick();
      chk("busy_done", {31'd0, busy}, 32'd0);
      chk("count_after_add", {30'd0, digit_count}, 32'd1);
      chk("busy_commit_ignored", {31'd0, value_valid}, 32'd0);

      // Commit and digit in the same cycle: digit wins
      digit = 4'd1;
      digit_valid = 1'b1;
      commit = 1'b1;
      tick();
      digit_valid = 1'b0;
      commit = 1'b0;
      tick();
      tick();
      tick();
      chk("same_cycle_count", {30'd0, digit_count}, 32'd2);
      chk("same_cycle_valid", {31'd0, value_valid}, 32'd0);
      do_commit();
      chk("same_cycle_value", {24'd0, value}, 32'd61);
      handoff();

      // Invalid code discarded, then 4th digit refused
      enter_digit(4'd1);
      enter_digit(4'd2);
      digit = 4'hB;
      digit_valid = 1'b1;
      chk("bad_digit_ready", {31'd0, digit_ready}, 32'd1);
      tick();
      digit_valid = 1'b0;
      chk("bad_digit_busy", {31'd0, busy}, 32'd0);
      chk("bad_digit_count", {30'd0, digit_count}, 32'd2);
      enter_digit(4'd3);
      chk("full_count", {30'd0, digit_count}, 32'd3);
      digit = 4'd4;
      digit_valid = 1'b1;
      chk("full_ready", {31'd0, digit_ready}, 32'd0);
      tick();
      tick();
      digit_valid = 1'b0;
      chk("full_busy", {31'd0, busy}, 32'd0);
      chk("full_count_hold", {30'd0, digit_count}, 32'd3);
      do_commit();
      chk("full_value", {24'd0, value}, 32'd123);
      handoff();

      // Sign toggle that would overflow (-128 -> +128)
      pulse_neg();
      enter_digit(4'd1);
      enter_digit(4'd2);
      enter_digit(4'd8);
      pulse_neg();
      chk("neg_ovf", {31'd0, ovf}, 32'd1);
      do_commit();
`ifdef ENTRY_SAT_EN
      chk("neg_ovf_value", {24'd0, value}, 32'h7F);
`else
      chk("neg_ovf_value", {24'd0, value}, 32'h80);
`endif
      handoff();

      // clr in X2 after 5,5
      enter_digit(4'd5);
      digit = 4'd5;
      digit_valid = 1'b1;
      tick();
      digit_valid = 1'b0;
      tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_busy", {31'd0, busy}, 32'd0);
      chk("clr_count", {30'd0, digit_count}, 32'd0);
      chk("clr_ovf", {31'd0, ovf}, 32'd0);
      chk("clr_ready", {31'd0, digit_ready}, 32'd1);
      enter_digit(4'd3);
      do_commit();
      chk("clr_then_value", {24'd0, value}, 32'd3);
      handoff();

      // clr clears a sticky overflow
      enter_digit(4'd9);
      enter_digit(4'd9);
      enter_digit(4'd9);
      chk("sticky_ovf", {31'd0, ovf}, 32'd1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_sticky_ovf", {31'd0, ovf}, 32'd0);
      chk("clr_sticky_count", {30'd0, digit_count}, 32'd0);

      // clr during HOLD
      enter_digit(4'd7);
      do_commit();
      chk("hold_valid", {31'd0, value_valid}, 32'd1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_hold_valid", {31'd0, value_valid}, 32'd0);
      chk("clr_hold_count", {30'd0, digit_count}, 32'd0);

      // Backpressure: 42 held stable for 5 cycles
      enter_digit(4'd4);
      enter_digit(4'd2);
      do_commit();
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("bp_value_%0d", c), {24'd0, value}, 32'd42);
         chk($sformatf("bp_valid_%0d", c), {31'd0, value_valid}, 32'd1);
         chk($sformatf("bp_ready_%0d", c), {31'd0, digit_ready}, 32'd0);
         tick();
      end
      handoff();
      chk("bp_post_valid", {31'd0, value_valid}, 32'd0);
      chk("bp_post_count", {30'd0, digit_count}, 32'd0);

      // Asynchronous reset mid-sequence
      enter_digit(4'd4);
      digit = 4'd7;
      digit_valid = 1'b1;
      tick();
      digit_valid = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_count", {30'd0, digit_count}, 32'd0);
      tick();
      rst = 1'b1;
      tick();
      enter_digit(4'd6);
      do_commit();
      chk("arst_then_value", {24'd0, value}, 32'd6);
      handoff();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
